// File: rtl/atm_pkg.sv
// Shared definitions for the ATM PIN entry block: default sizing, FSM state
// encoding and a BCD digit check.
package atm_pkg;

  localparam int unsigned PIN_DIGITS_DEF = 4;
  localparam int unsigned MAX_TRIES_DEF  = 3;
  localparam int unsigned DIGIT_W        = 4;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_COLLECT     = 3'd1,
    S_CHECK       = 3'd2,
    S_RESULT      = 3'd3,
    S_LOCKED      = 3'd4,
    S_WAIT_REMOVE = 3'd5
  } state_e;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= DIGIT_W'(9);
  endfunction

endpackage

// File: rtl/atm_pin_entry_if.sv
// Keypad, card and verdict signals of the PIN entry block; master drives the
// keypad/card side, slave is the PIN entry block itself.
interface atm_pin_entry_if #(
  parameter int unsigned PIN_DIGITS = atm_pkg::PIN_DIGITS_DEF
) ();
  localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);
  localparam int unsigned BUF_W = atm_pkg::DIGIT_W * PIN_DIGITS;

  logic                                card_in;
  logic                                key_valid;
  logic [atm_pkg::DIGIT_W-1:0]         key_digit;
  logic                                key_enter;
  logic                                key_clear;
  logic [BUF_W-1:0]                    stored_pin;
  logic                                timeout;
  logic                                psw_en;
  logic                                wrong_psw;
  logic                                locked;
  logic [CNT_W-1:0]                    digit_count;
  logic                                restart_timer;

  modport master (
    output card_in, key_valid, key_digit, key_enter, key_clear, stored_pin, timeout,
    input  psw_en, wrong_psw, locked, digit_count, restart_timer
  );

  modport slave (
    input  card_in, key_valid, key_digit, key_enter, key_clear, stored_pin, timeout,
    output psw_en, wrong_psw, locked, digit_count, restart_timer
  );
endinterface

// File: rtl/atm_pin_shift_reg.sv
// BCD digit buffer: new digits enter the least significant nibble, so after
// PIN_DIGITS keys the first key typed sits in the most significant nibble.
module atm_pin_shift_reg
  import atm_pkg::*;
#(
  parameter  int unsigned PIN_DIGITS = PIN_DIGITS_DEF,
  localparam int unsigned CNT_W      = $clog2(PIN_DIGITS + 1),
  localparam int unsigned BUF_W      = DIGIT_W * PIN_DIGITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_shift,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [BUF_W-1:0]   o_buf,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_full_c
);

  logic [BUF_W-1:0] r_buf;
  logic [CNT_W-1:0] r_count;

  assign o_full_c = (r_count == CNT_W'(PIN_DIGITS));
  assign o_buf    = r_buf;
  assign o_count  = r_count;

  // Clear wins over shift; shifting a full buffer is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_buf   <= '0;
      r_count <= '0;
    end else if (i_shift && !o_full_c) begin
      r_buf   <= (r_buf << DIGIT_W) | BUF_W'(i_digit);
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/atm_pin_entry.sv
// ATM PIN entry controller: collects keypad digits, compares against the
// account PIN, reports a one-cycle verdict and locks the card after MAX_TRIES.
module atm_pin_entry
  import atm_pkg::*;
#(
  parameter int unsigned PIN_DIGITS = PIN_DIGITS_DEF,
  parameter int unsigned MAX_TRIES  = MAX_TRIES_DEF
) (
  input logic            clk,
  input logic            rst,
  atm_pin_entry_if.slave bus
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned BUF_W = DIGIT_W * PIN_DIGITS;

  state_e           r_state, w_next;
  logic [TRY_W-1:0] r_tries, w_tries;
  logic             r_psw_en, w_psw_en;
  logic             r_wrong, w_wrong;
  logic             r_locked, w_locked;
  logic             r_restart, w_restart;
  logic             w_sr_clear, w_sr_shift;
  logic [BUF_W-1:0] w_buf;
  logic             w_full;

  atm_pin_shift_reg #(.PIN_DIGITS(PIN_DIGITS)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_sr_clear),
    .i_shift  (w_sr_shift),
    .i_digit  (bus.key_digit),
    .o_buf    (w_buf),
    .o_count  (bus.digit_count),
    .o_full_c (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tries   <= '0;
      r_psw_en  <= 1'b0;
      r_wrong   <= 1'b0;
      r_locked  <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tries   <= w_tries;
      r_psw_en  <= w_psw_en;
      r_wrong   <= w_wrong;
      r_locked  <= w_locked;
      r_restart <= w_restart;
    end
  end

  // Card removal overrides everything; within COLLECT: timeout > clear > enter > digit.
  always_comb begin
    w_next     = r_state;
    w_tries    = r_tries;
    w_psw_en   = 1'b0;
    w_wrong    = r_wrong;
    w_locked   = r_locked;
    w_restart  = 1'b0;
    w_sr_clear = 1'b0;
    w_sr_shift = 1'b0;

    if (!bus.card_in) begin
      w_next     = S_IDLE;
      w_tries    = '0;
      w_wrong    = 1'b0;
      w_locked   = 1'b0;
      w_sr_clear = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next     = S_COLLECT;
          w_tries    = '0;
          w_sr_clear = 1'b1;
          w_restart  = 1'b1;
        end
        S_COLLECT: begin
          if (bus.timeout) begin
            w_next     = S_WAIT_REMOVE;
            w_sr_clear = 1'b1;
          end else if (bus.key_clear) begin
            w_sr_clear = 1'b1;
            w_restart  = 1'b1;
          end else if (bus.key_enter) begin
            w_next = S_CHECK;
          end else if (bus.key_valid && is_bcd(bus.key_digit) && !w_full) begin
            w_sr_shift = 1'b1;
            w_restart  = 1'b1;
          end
        end
        S_CHECK: begin
          // Verdict registers here so it is presented during RESULT.
          w_next   = S_RESULT;
          w_psw_en = 1'b1;
          w_wrong  = !(w_full && (w_buf == bus.stored_pin));
        end
        S_RESULT: begin
          if (!r_wrong) begin
            w_next  = S_WAIT_REMOVE;
            w_tries = '0;
          end else if (r_tries == TRY_W'(MAX_TRIES - 1)) begin
            w_next   = S_LOCKED;
            w_tries  = r_tries + TRY_W'(1);
            w_locked = 1'b1;
          end else begin
            w_next     = S_COLLECT;
            w_tries    = r_tries + TRY_W'(1);
            w_sr_clear = 1'b1;
            w_restart  = 1'b1;
          end
        end
        S_LOCKED, S_WAIT_REMOVE: w_next = r_state;
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign bus.psw_en        = r_psw_en;
  assign bus.wrong_psw     = r_wrong;
  assign bus.locked        = r_locked;
  assign bus.restart_timer = r_restart;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: directed scenarios plus random keypad sessions,
// verdicts checked by a monitor against a queue filled by a PIN-queue model.
module tb_atm_pin_entry;
  import atm_pkg::*;

  localparam int unsigned PD = 4;
  localparam int unsigned MT = 3;

  logic clk = 1'b0;
  logic rst;

  atm_pin_entry_if #(.PIN_DIGITS(PD)) bus ();

  atm_pin_entry #(.PIN_DIGITS(PD), .MAX_TRIES(MT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit wrong;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Verdict monitor: every psw_en cycle must match the next queued verdict.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.psw_en !== 1'b0) begin
      if (exp_q.size() == 0) chk("unexpected_psw_en", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("psw_en_cycle", cyc, e.cyc);
        chk("wrong_psw", int'(bus.wrong_psw), int'(e.wrong));
      end
    end
  end

  // Reference model: entered digits as a queue, session mode, failed tries.
  typedef enum {M_IDLE, M_COLL, M_DONE, M_LOCK} mode_e;
  mode_e          mode = M_IDLE;
  int             q[$];
  int             tries = 0;
  bit             m_locked = 0;
  bit             last_wrong = 0;
  logic [4*PD-1:0] pin;

  task automatic zero_keys();
    bus.key_valid = 1'b0;
    bus.key_enter = 1'b0;
    bus.key_clear = 1'b0;
    bus.key_digit = 4'd0;
    bus.timeout   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_card_out();
    mode = M_IDLE; q.delete(); tries = 0; m_locked = 0; last_wrong = 0;
  endtask

  // Junk keys during CHECK/RESULT must be ignored.
  task automatic junk_keys();
    bus.key_valid = 1'($urandom);
    bus.key_enter = 1'($urandom);
    bus.key_clear = 1'($urandom);
    bus.key_digit = 4'($urandom);
    bus.timeout   = 1'($urandom);
  endtask

  task automatic key(input bit clr, input bit ent, input bit vld, input int d, input bit to);
    bit exp_rst = 0;
    bit do_enter = 0;
    bit wrong;
    bit exp_restart2;
    longint v = 0;
    bus.key_clear = clr;
    bus.key_enter = ent;
    bus.key_valid = vld;
    bus.key_digit = 4'(d);
    bus.timeout   = to;
    if (mode == M_COLL) begin
      if (to) begin
        q.delete(); mode = M_DONE;
      end else if (clr) begin
        q.delete(); exp_rst = 1;
      end else if (ent) begin
        do_enter = 1;
      end else if (vld && d <= 9 && q.size() < PD) begin
        q.push_back(d); exp_rst = 1;
      end
    end
    if (do_enter) begin
      foreach (q[i]) v = v * 16 + q[i];
      wrong = !(q.size() == PD && v == longint'(pin));
      exp_q.push_back('{cyc: cyc + 2, wrong: wrong});
    end
    step();
    zero_keys();
    chk("digit_count", int'(bus.digit_count), q.size());
    chk("restart_timer", int'(bus.restart_timer), int'(exp_rst));
    chk("locked", int'(bus.locked), int'(m_locked));
    chk("wrong_psw_hold", int'(bus.wrong_psw), int'(last_wrong));
    if (do_enter) begin
      junk_keys();
      step();
      zero_keys();
      last_wrong = wrong;
      exp_restart2 = 0;
      if (!wrong) begin
        mode = M_DONE; tries = 0;
      end else begin
        tries++;
        if (tries == MT) begin
          mode = M_LOCK; m_locked = 1;
        end else begin
          mode = M_COLL; q.delete(); exp_restart2 = 1;
        end
      end
      junk_keys();
      step();
      zero_keys();
      chk("locked_after_verdict", int'(bus.locked), int'(m_locked));
      chk("restart_after_verdict", int'(bus.restart_timer), int'(exp_restart2));
      chk("count_after_verdict", int'(bus.digit_count), q.size());
      chk("wrong_psw_held", int'(bus.wrong_psw), int'(last_wrong));
    end
  endtask

  task automatic digit(input int d);
    key(0, 0, 1, d, 0);
  endtask

  task automatic enter();
    key(0, 1, 0, 0, 0);
  endtask

  task automatic card(input bit on);
    bit was_idle = (mode == M_IDLE);
    bus.card_in = on;
    step();
    if (!on) begin
      model_card_out();
      chk("card_out_locked", int'(bus.locked), 0);
      chk("card_out_wrong", int'(bus.wrong_psw), 0);
      chk("card_out_count", int'(bus.digit_count), 0);
      chk("card_out_restart", int'(bus.restart_timer), 0);
    end else begin
      if (was_idle) mode = M_COLL;
      chk("card_in_restart", int'(bus.restart_timer), int'(was_idle));
      chk("card_in_count", int'(bus.digit_count), q.size());
    end
  endtask

  function automatic int pin_digit(input int idx);
    return int'((pin >> (4 * (PD - 1 - idx))) & 16'hF);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1;
    bus.card_in = 1'b0;
    pin = 16'h1234;
    bus.stored_pin = pin;
    zero_keys();
    #3;
    chk("reset_psw_en", int'(bus.psw_en), 0);
    chk("reset_wrong", int'(bus.wrong_psw), 0);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_count", int'(bus.digit_count), 0);
    chk("reset_restart", int'(bus.restart_timer), 0);
    @(negedge clk);
    rst = 1'b0;

    // Correct PIN, then keys ignored while waiting for removal.
    card(1);
    digit(1); digit(2); digit(3); digit(4); enter();
    digit(5); enter();
    card(0);

    // Three wrong PINs lock the card; removal unlocks.
    card(1);
    repeat (3) begin
      digit(1); digit(2); digit(3); digit(5); enter();
    end
    digit(1); enter();
    card(0);

    // Short PIN, then overfull buffer.
    card(1);
    digit(1); digit(2); enter();
    digit(1); digit(2); digit(3); digit(4); digit(5); digit(12);
    enter();
    card(0);

    // Clear beats enter in the same cycle.
    card(1);
    digit(9); digit(9); key(1, 1, 1, 7, 0);
    digit(1); digit(2); digit(3); digit(4); enter();
    card(0);

    // Timeout after two digits; card pulled mid-entry.
    card(1);
    digit(1); digit(2); key(0, 0, 0, 0, 1);
    digit(3); enter();
    card(0);
    card(1);
    digit(1); digit(2); digit(3);
    card(0);

    // Asynchronous reset while the verdict is in flight.
    card(1);
    digit(1); digit(2); digit(3); digit(4);
    bus.key_enter = 1'b1;
    step();
    zero_keys();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", int'(bus.digit_count), 0);
    chk("async_rst_psw_en", int'(bus.psw_en), 0);
    chk("async_rst_locked", int'(bus.locked), 0);
    @(posedge clk);
    #1;
    chk("rst_held_psw_en", int'(bus.psw_en), 0);
    @(negedge clk);
    rst = 1'b0;
    model_card_out();
    card(1);
    repeat (4) key(0, 0, 0, 0, 0);
    card(0);

    // Random sessions against a random BCD PIN.
    repeat (30) begin
      for (int i = 0; i < PD; i++) pin = (pin << 4) | (4*PD)'($urandom_range(0, 9));
      bus.stored_pin = pin;
      card(1);
      repeat (25) begin
        r = $urandom_range(0, 99);
        if (r < 60) begin
          if ($urandom_range(0, 3) != 0 && q.size() < PD) digit(pin_digit(q.size()));
          else digit($urandom_range(0, 15));
        end else if (r < 68) key(1, 0, 0, 0, 0);
        else if (r < 82) enter();
        else if (r < 85) key(0, 0, 0, 0, 1);
        else if (r < 93) key(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15), 0);
        else key(0, 0, 0, 0, 0);
      end
      card(0);
    end

    repeat (3) step();
    chk("pending_verdicts", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
